instr_fetch_ctrl: RTL and testbench

- Owns the program counter and sequences the 16-bit instruction memory, which has a 1-cycle registered read.
- Presents a stream of instructions to decode, with stall and branch-redirect handling.
- Shares the memory port with a program loader, so a new program can be written before the core runs.
- Sits between the loader, the instruction memory and the decode stage.

---
 rtl/riscpkg.sv | 15 +
 rtl/instr_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscpkg.sv
// Shared definitions for the fetch front end: default widths, reset vector
// and the fetch controller state encoding.
package riscpkg;

    localparam int PROG_CTR_WID_DEF = 10;
    localparam int INSTR_WID        = 16;
    localparam int RESET_VEC_DEF    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Program counter and instruction-memory sequencer; the memory port is shared
// between the program loader (LOAD) and instruction fetch (FETCH).
module instr_fetch_ctrl
    import riscpkg::*;
#(
    parameter int                    PROG_CTR_WID = PROG_CTR_WID_DEF,
    parameter logic [PROG_CTR_WID-1:0] RESET_VEC  = PROG_CTR_WID'(RESET_VEC_DEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [PROG_CTR_WID-1:0] branch_target,
    input  logic                    ld_req,
    input  logic [PROG_CTR_WID-1:0] ld_addr,
    input  logic [INSTR_WID-1:0]    ld_data,
    output logic                    ld_gnt,
    output logic [PROG_CTR_WID-1:0] mem_addr,
    output logic                    mem_we,
    output logic [INSTR_WID-1:0]    mem_wdata,
    input  logic [INSTR_WID-1:0]    mem_rdata,
    output logic [INSTR_WID-1:0]    instr_out,
    output logic                    instr_valid,
    output logic [PROG_CTR_WID-1:0] instr_pc
);

    fetch_state_e              state_q, state_d;
    logic [PROG_CTR_WID-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PROG_CTR_WID-1:0]   instr_pc_q, instr_pc_d;
    logic                      instr_valid_q, instr_valid_d;
    logic [PROG_CTR_WID-1:0]   fetch_addr_s;

    // Fetch address: branch beats stall; a stalled live word is re-read so
    // the registered memory output holds it stable for decode.
    always_comb begin
        if (branch_taken) begin
            fetch_addr_s = branch_target;
        end else if (stall && instr_valid_q) begin
            fetch_addr_s = instr_pc_q;
        end else begin
            fetch_addr_s = fetch_pc_q;
        end
    end

    // Next-state, next-PC and memory-port steering.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        mem_addr      = fetch_pc_q;
        mem_we        = 1'b0;
        mem_wdata     = {INSTR_WID{1'b0}};
        ld_gnt        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_req) begin
                    state_d = LOAD;
                end else if (run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                ld_gnt    = 1'b1;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                mem_we    = ld_req;
                if (!ld_req) begin
                    state_d    = IDLE;
                    fetch_pc_d = RESET_VEC;
                end else begin
                    state_d = LOAD;
                end
            end
            FETCH: begin
                mem_addr = fetch_addr_s;
                if (run) begin
                    instr_pc_d    = fetch_addr_s;
                    instr_valid_d = 1'b1;
                    if (!stall || branch_taken) begin
                        fetch_pc_d = fetch_addr_s + PROG_CTR_WID'(1);
                    end else begin
                        fetch_pc_d = fetch_pc_q;
                    end
                end else begin
                    // Leaving FETCH keeps fetch_pc so re-entry resumes in place.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, program counters and valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_VEC;
            instr_pc_q    <= RESET_VEC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr_out   = mem_rdata;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          run;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic          ld_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic [15:0]   instr_out;
    logic          instr_valid;
    logic [AW-1:0] instr_pc;

    int checks = 0;
    int errors = 0;

    instr_fetch_ctrl #(.PROG_CTR_WID(AW), .RESET_VEC(10'd0)) dut (
        .clk(clk), .reset(reset), .run(run), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .instr_out(instr_out),
        .instr_valid(instr_valid), .instr_pc(instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory with 1-cycle registered read and a write port.
    logic [15:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Behavioural model: what the port does and which word is on show.
    localparam int M_IDLE = 0, M_LOAD = 1, M_FETCH = 2;
    int            m_mode;
    logic [AW-1:0] m_next;
    logic [AW-1:0] m_pc;
    logic          m_valid;
    logic [15:0]   golden [DEPTH];

    function automatic logic [AW-1:0] model_addr();
        if (m_mode == M_LOAD) return ld_addr;
        if (m_mode == M_FETCH) begin
            if (branch_taken) return branch_target;
            if (stall && m_valid) return m_pc;
        end
        return m_next;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  <= M_IDLE;
            m_next  <= 10'd0;
            m_pc    <= 10'd0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_mode == M_IDLE) begin
                if (ld_req) m_mode <= M_LOAD;
                else if (run) m_mode <= M_FETCH;
            end else if (m_mode == M_LOAD) begin
                if (ld_req) golden[ld_addr] <= ld_data;
                else begin
                    m_mode <= M_IDLE;
                    m_next <= 10'd0;
                end
            end else if (!run) begin
                m_mode <= M_IDLE;
            end else begin
                m_pc    <= model_addr();
                m_valid <= 1'b1;
                if (!stall || branch_taken) m_next <= model_addr() + 10'd1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_valid", int'(instr_valid), int'(m_valid));
        chk("m_pc", int'(instr_pc), int'(m_pc));
        chk("m_addr", int'(mem_addr), int'(model_addr()));
        chk("m_gnt", int'(ld_gnt), int'(m_mode == M_LOAD));
        chk("m_we", int'(mem_we), int'(m_mode == M_LOAD && ld_req));
        chk("m_wdata", int'(mem_wdata), (m_mode == M_LOAD) ? int'(ld_data) : 0);
        if (m_valid) chk("m_instr", int'(instr_out), int'(golden[m_pc]));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 16'hA000 + 16'(i);
            golden[i] = 16'hA000 + 16'(i);
        end
        reset = 1'b1; run = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 10'd0; ld_req = 1'b0; ld_addr = 10'd0; ld_data = 16'h0000;
        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_gnt", int'(ld_gnt), 0);
        chk("rst_we", int'(mem_we), 0);
        run = 1'b1;
        step();
        chk("entry_valid", int'(instr_valid), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("seq_valid", int'(instr_valid), 1);
            chk("seq_pc", int'(instr_pc), i);
            chk("seq_data", int'(instr_out), 'hA000 + i);
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", int'(instr_pc), 5);
            chk("stall_data", int'(instr_out), 'hA005);
        end
        stall = 1'b0;
        step();
        chk("release_pc", int'(instr_pc), 6);
        for (int s = 0; s < 2; s++) begin
            branch_taken = 1'b1; branch_target = 10'h200; stall = (s == 1);
            step();
            branch_taken = 1'b0; stall = 1'b0;
            chk("br_pc", int'(instr_pc), 'h200);
            chk("br_data", int'(instr_out), 'hA200);
            step();
            chk("br_next_pc", int'(instr_pc), 'h201);
        end
        run = 1'b0;
        step();
        chk("idle_valid", int'(instr_valid), 0);
        ld_req = 1'b1;
        #1;
        chk("idle_gnt", int'(ld_gnt), 0);
        step();
        chk("load_gnt", int'(ld_gnt), 1);
        for (int k = 0; k < 4; k++) begin
            ld_addr = 10'(k); ld_data = 16'hBEE0 + 16'(k);
            #1;
            chk("load_we", int'(mem_we), 1);
            chk("load_addr", int'(mem_addr), k);
            step();
        end
        ld_req = 1'b0; run = 1'b1;
        #1;
        chk("load_end_gnt", int'(ld_gnt), 1);
        chk("load_end_we", int'(mem_we), 0);
        step();
        chk("post_load_gnt", int'(ld_gnt), 0);
        step();
        chk("refetch_entry", int'(instr_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("refetch_pc", int'(instr_pc), k);
            chk("refetch_data", int'(instr_out), 'hBEE0 + k);
        end
        ld_req = 1'b1; ld_addr = 10'h100; ld_data = 16'h1234;
        #1;
        chk("fetch_ld_gnt", int'(ld_gnt), 0);
        chk("fetch_ld_we", int'(mem_we), 0);
        step();
        chk("fetch_ld_gnt2", int'(ld_gnt), 0);
        chk("fetch_ld_pc", int'(instr_pc), 4);
        run = 1'b0;
        step();
        chk("stop_gnt", int'(ld_gnt), 0);
        step();
        chk("late_load_gnt", int'(ld_gnt), 1);
        ld_req = 1'b0;
        step();
        run = 1'b1;
        step();
        branch_taken = 1'b1; branch_target = 10'h3FE;
        step();
        branch_taken = 1'b0;
        chk("wrap_pc0", int'(instr_pc), 'h3FE);
        chk("wrap_data0", int'(instr_out), 'hA3FE);
        step();
        chk("wrap_pc1", int'(instr_pc), 'h3FF);
        step();
        chk("wrap_pc2", int'(instr_pc), 0);
        chk("wrap_data2", int'(instr_out), 'hBEE0);
        chk("pre_rst_addr", int'(mem_addr), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_valid", int'(instr_valid), 0);
        chk("async_addr", int'(mem_addr), 0);
        repeat (2) step();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            run           = ($urandom_range(0, 9) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = 10'($urandom);
            if ($urandom_range(0, 29) == 0) ld_req = ~ld_req;
            ld_addr       = 10'($urandom);
            ld_data       = 16'($urandom);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
